// File: rtl/spike_fanout_sched.sv
`timescale 1ns/1ps
// spike_fanout_sched
// Per-timestep spike dispatcher for the 4-edge fan-out walker. It latches a
// timestep spike vector and hands each spiking neuron ID to the walker in
// ascending order. It waits for the walker's last edge before issuing the next
// ID. It counts issued sources and observed edges. It flags any step whose
// edge total differs from sources * EDGES_PER_SRC, and any edge seen while idle.
//
// Ports:
//   clk, rst (sync, active-high), clk_en (freezes all state when low)
//   step_valid / step_ready / step_spikes   : timestep vector handshake
//   wr_req_valid / wr_req_ready / wr_req_src_id : request to the walker
//   wr_edge_fire, wr_out_last               : walker output observation
//   step_done    : one enabled-cycle pulse when the step is fully dispatched
//   busy         : controller not idle
//   spike_cnt, edge_cnt : per-step statistics (saturating, held after done)
//   err_edge_mismatch   : sticky error, cleared only by rst
module spike_fanout_sched #(
    parameter int N_NEURON      = 64,
    parameter int NEURON_ID_W   = (N_NEURON <= 2) ? 1 : $clog2(N_NEURON),
    parameter int EDGES_PER_SRC = 4,
    parameter int CNT_W         = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_en,
    input  logic                   step_valid,
    output logic                   step_ready,
    input  logic [N_NEURON-1:0]    step_spikes,
    output logic                   wr_req_valid,
    input  logic                   wr_req_ready,
    output logic [NEURON_ID_W-1:0] wr_req_src_id,
    input  logic                   wr_edge_fire,
    input  logic                   wr_out_last,
    output logic                   step_done,
    output logic                   busy,
    output logic [CNT_W-1:0]       spike_cnt,
    output logic [CNT_W-1:0]       edge_cnt,
    output logic                   err_edge_mismatch
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Product width wide enough that spike_cnt * EDGES_PER_SRC never truncates.
    localparam int EPS_W  = (EDGES_PER_SRC <= 1) ? 1 : $clog2(EDGES_PER_SRC + 1);
    localparam int PROD_W = CNT_W + EPS_W;

    state_t                   state_r, state_s;
    logic [N_NEURON-1:0]      mask_r, mask_s;
    logic [NEURON_ID_W-1:0]   cur_id_r, cur_id_s;
    logic [CNT_W-1:0]         spike_r, spike_s;
    logic [CNT_W-1:0]         edge_r, edge_s;
    logic                     err_r, err_s;
    logic [NEURON_ID_W-1:0]   low_id_s;
    logic [PROD_W-1:0]        exp_edges_s;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [NEURON_ID_W-1:0] lowest_set(input logic [N_NEURON-1:0] v);
        logic [NEURON_ID_W-1:0] idx;
        idx = '0;
        for (int i = N_NEURON - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = NEURON_ID_W'(i);
            end
        end
        return idx;
    endfunction

    // Increment that sticks at the all-ones value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    assign low_id_s    = lowest_set(mask_r);
    assign exp_edges_s = PROD_W'(spike_r) * PROD_W'(EDGES_PER_SRC);

    // Next-state and register-update logic for the dispatch FSM.
    always_comb begin
        state_s  = state_r;
        mask_s   = mask_r;
        cur_id_s = cur_id_r;
        spike_s  = spike_r;
        edge_s   = edge_r;
        err_s    = err_r;

        // Edges count in every active state, including the cycle carrying out_last.
        if ((state_r != ST_IDLE) && wr_edge_fire) begin
            edge_s = sat_inc(edge_r);
        end else begin
            edge_s = edge_r;
        end

        case (state_r)
            ST_IDLE: begin
                // An edge while idle cannot belong to any issued source.
                if (wr_edge_fire) begin
                    err_s = 1'b1;
                end else begin
                    err_s = err_r;
                end
                if (step_valid) begin
                    mask_s  = step_spikes;
                    spike_s = '0;
                    edge_s  = '0;
                    state_s = ST_SCAN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (mask_r == '0) begin
                    state_s = ST_DONE;
                end else begin
                    cur_id_s = low_id_s;
                    state_s  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (wr_req_ready) begin
                    mask_s[cur_id_r] = 1'b0;
                    spike_s          = sat_inc(spike_r);
                    state_s          = ST_WAIT;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (wr_out_last) begin
                    state_s = ST_SCAN;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (PROD_W'(edge_r) != exp_edges_s) begin
                    err_s = 1'b1;
                end else begin
                    err_s = err_r;
                end
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State registers; synchronous reset wins, clk_en low freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            mask_r   <= '0;
            cur_id_r <= '0;
            spike_r  <= '0;
            edge_r   <= '0;
            err_r    <= 1'b0;
        end else if (clk_en) begin
            state_r  <= state_s;
            mask_r   <= mask_s;
            cur_id_r <= cur_id_s;
            spike_r  <= spike_s;
            edge_r   <= edge_s;
            err_r    <= err_s;
        end else begin
            state_r  <= state_r;
            mask_r   <= mask_r;
            cur_id_r <= cur_id_r;
            spike_r  <= spike_r;
            edge_r   <= edge_r;
            err_r    <= err_r;
        end
    end

    // Handshake qualifiers follow clk_en so nothing is accepted or reported
    // while the block is frozen.
    assign step_ready        = (state_r == ST_IDLE) && clk_en;
    assign step_done         = (state_r == ST_DONE) && clk_en;
    assign wr_req_valid      = (state_r == ST_ISSUE);
    assign wr_req_src_id     = cur_id_r;
    assign busy              = (state_r != ST_IDLE);
    assign spike_cnt         = spike_r;
    assign edge_cnt          = edge_r;
    assign err_edge_mismatch = err_r;

endmodule

// File: tb/tb_spike_fanout_sched.sv
`timescale 1ns/1ps
// Directed bench for spike_fanout_sched with a small behavioural walker model.
module tb_spike_fanout_sched;

    logic        clk;
    logic        rst;
    logic        clk_en;
    logic        step_valid;
    logic        step_ready;
    logic [63:0] step_spikes;
    logic        wr_req_valid;
    logic        wr_req_ready;
    logic [5:0]  wr_req_src_id;
    logic        wr_edge_fire;
    logic        wr_out_last;
    logic        step_done;
    logic        busy;
    logic [15:0] spike_cnt;
    logic [15:0] edge_cnt;
    logic        err_edge_mismatch;

    spike_fanout_sched #(
        .N_NEURON(64), .EDGES_PER_SRC(4), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .step_valid(step_valid), .step_ready(step_ready), .step_spikes(step_spikes),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_req_src_id(wr_req_src_id),
        .wr_edge_fire(wr_edge_fire), .wr_out_last(wr_out_last),
        .step_done(step_done), .busy(busy),
        .spike_cnt(spike_cnt), .edge_cnt(edge_cnt),
        .err_edge_mismatch(err_edge_mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Walker model configuration (driven by the stimulus block only).
    logic [7:0] n_edges;
    int         rq_block_cfg;
    logic       toggle_cfg;

    // Walker model state.
    logic [7:0] rem;
    logic       tog;
    int         blk_cnt;
    logic       out_rdy;

    assign out_rdy      = (toggle_cfg == 1'b0) || tog;
    assign wr_edge_fire = (rem != 8'd0) && out_rdy;
    assign wr_out_last  = wr_edge_fire && (rem == 8'd1);
    assign wr_req_ready = (blk_cnt >= rq_block_cfg);

    always @(posedge clk) begin
        if (rst) begin
            rem     <= 8'd0;
            tog     <= 1'b0;
            blk_cnt <= 0;
        end else if (clk_en) begin
            tog <= ~tog;
            if (wr_req_valid && wr_req_ready) begin
                rem     <= n_edges;
                blk_cnt <= 0;
            end else begin
                if (wr_edge_fire) rem <= rem - 8'd1;
                if (wr_req_valid && !wr_req_ready) blk_cnt <= blk_cnt + 1;
            end
        end
    end

    // Monitor: cycle stamps, issued IDs, done pulses, request stability.
    int         cyc = 0;
    int         acc_cyc = 0;
    int         done_cyc = 0;
    int         done_n = 0;
    int         req_n = 0;
    int         viol = 0;
    logic [5:0] req_log [0:63];
    logic       pend = 1'b0;
    logic [5:0] pend_id = 6'd0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && clk_en) begin
            if (step_valid && step_ready) acc_cyc <= cyc;
            if (step_done) begin
                done_n   <= done_n + 1;
                done_cyc <= cyc;
            end
            if (wr_req_valid && wr_req_ready) begin
                req_log[req_n[5:0]] <= wr_req_src_id;
                req_n <= req_n + 1;
            end
        end
        pend    <= wr_req_valid && !wr_req_ready;
        pend_id <= wr_req_src_id;
        if (pend && wr_req_valid && (wr_req_src_id != pend_id)) viol <= viol + 1;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one vector, then wait (bounded) for its step_done pulse.
    task automatic run_step(input logic [63:0] sp, input int budget);
        int d0;
        d0 = done_n;
        step_spikes = sp;
        step_valid  = 1'b1;
        tick();
        step_valid  = 1'b0;
        for (int i = 0; (i < budget) && (done_n == d0); i++) tick();
        chk("step_done_seen", 64'(done_n - d0), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int d0;
        rst = 1'b1; clk_en = 1'b1; step_valid = 1'b0; step_spikes = 64'd0;
        n_edges = 8'd4; rq_block_cfg = 0; toggle_cfg = 1'b0;
        tick(); tick();

        // Reset values.
        chk("rst_step_ready", step_ready, 1'b1);
        chk("rst_req_valid", wr_req_valid, 1'b0);
        chk("rst_src_id", wr_req_src_id, 6'd0);
        chk("rst_step_done", step_done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_spike_cnt", spike_cnt, 16'd0);
        chk("rst_edge_cnt", edge_cnt, 16'd0);
        chk("rst_err", err_edge_mismatch, 1'b0);
        rst = 1'b0;
        tick();

        // Empty step.
        run_step(64'd0, 20);
        chk("empty_latency", 64'(done_cyc - acc_cyc), 64'd2);
        chk("empty_spike_cnt", spike_cnt, 16'd0);
        chk("empty_edge_cnt", edge_cnt, 16'd0);
        chk("empty_err", err_edge_mismatch, 1'b0);
        chk("empty_ready_after", step_ready, 1'b1);

        // Ordering with an always-ready walker.
        r0 = req_n;
        run_step((64'd1 << 3) | (64'd1 << 10), 100);
        chk("ord_req_count", 64'(req_n - r0), 64'd2);
        chk("ord_id0", req_log[r0[5:0]], 6'd3);
        chk("ord_id1", req_log[6'(r0 + 1)], 6'd10);
        chk("ord_spike_cnt", spike_cnt, 16'd2);
        chk("ord_edge_cnt", edge_cnt, 16'd8);
        chk("ord_latency", 64'(done_cyc - acc_cyc), 64'd14);
        chk("ord_err", err_edge_mismatch, 1'b0);

        // Backpressure on requests and on walker output.
        rq_block_cfg = 5; toggle_cfg = 1'b1;
        r0 = req_n;
        run_step((64'd1 << 3) | (64'd1 << 10), 200);
        chk("bp_id0", req_log[r0[5:0]], 6'd3);
        chk("bp_id1", req_log[6'(r0 + 1)], 6'd10);
        chk("bp_spike_cnt", spike_cnt, 16'd2);
        chk("bp_edge_cnt", edge_cnt, 16'd8);
        chk("bp_delayed", 64'(done_cyc - acc_cyc > 14), 64'd1);
        chk("bp_id_stable", 64'(viol), 64'd0);
        chk("bp_err", err_edge_mismatch, 1'b0);
        rq_block_cfg = 0; toggle_cfg = 1'b0;

        // Walker short by one edge: sticky error.
        n_edges = 8'd3;
        run_step(64'd1, 50);
        chk("mm_edge_cnt", edge_cnt, 16'd3);
        chk("mm_err", err_edge_mismatch, 1'b1);
        n_edges = 8'd4;
        run_step((64'd1 << 20) | (64'd1 << 21), 100);
        chk("mm_clean_edge_cnt", edge_cnt, 16'd8);
        chk("mm_err_sticky", err_edge_mismatch, 1'b1);

        // Reset during WAIT of the 2nd of 4 spikes.
        step_spikes = (64'd1 << 1) | (64'd1 << 2) | (64'd1 << 7) | (64'd1 << 9);
        step_valid  = 1'b1;
        tick();
        step_valid  = 1'b0;
        repeat (8) tick();
        chk("mid_in_wait", {busy, wr_req_valid, wr_req_src_id}, {1'b1, 1'b0, 6'd2});
        chk("mid_spike_cnt", spike_cnt, 16'd2);
        d0 = done_n;
        rst = 1'b1;
        tick();
        chk("mid_rst_ready", step_ready, 1'b1);
        chk("mid_rst_req_valid", wr_req_valid, 1'b0);
        chk("mid_rst_src_id", wr_req_src_id, 6'd0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_spike_cnt", spike_cnt, 16'd0);
        chk("mid_rst_edge_cnt", edge_cnt, 16'd0);
        chk("mid_rst_err", err_edge_mismatch, 1'b0);
        rst = 1'b0;
        tick();
        chk("mid_no_done", 64'(done_n - d0), 64'd0);
        r0 = req_n;
        run_step(64'd1 << 63, 50);
        chk("b63_id", req_log[r0[5:0]], 6'd63);
        chk("b63_spike_cnt", spike_cnt, 16'd1);
        chk("b63_edge_cnt", edge_cnt, 16'd4);
        chk("b63_err", err_edge_mismatch, 1'b0);

        // clk_en freeze in ISSUE and in DONE.
        d0 = done_n;
        step_spikes = 64'd1 << 5;
        step_valid  = 1'b1;
        tick();
        step_valid  = 1'b0;
        tick();
        chk("frz_issue", {wr_req_valid, wr_req_src_id}, {1'b1, 6'd5});
        clk_en = 1'b0;
        repeat (4) tick();
        chk("frz_issue_held", {wr_req_valid, wr_req_src_id, busy}, {1'b1, 6'd5, 1'b1});
        chk("frz_issue_spike_cnt", spike_cnt, 16'd0);
        clk_en = 1'b1;
        tick();
        chk("frz_after_hs_spike_cnt", spike_cnt, 16'd1);
        repeat (4) tick();
        tick();
        chk("frz_done_high", step_done, 1'b1);
        clk_en = 1'b0;
        #1;
        chk("frz_done_gated", step_done, 1'b0);
        repeat (4) tick();
        chk("frz_done_held", {busy, step_done, step_ready}, {1'b1, 1'b0, 1'b0});
        chk("frz_edge_cnt", edge_cnt, 16'd4);
        chk("frz_no_pulse_yet", 64'(done_n - d0), 64'd0);
        clk_en = 1'b1;
        #1;
        chk("frz_done_resume", step_done, 1'b1);
        tick();
        chk("frz_one_pulse", 64'(done_n - d0), 64'd1);
        chk("frz_idle", {busy, step_done, step_ready}, {1'b0, 1'b0, 1'b1});
        chk("frz_err", err_edge_mismatch, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
